// File: rtl/regfile_dump_reader.sv
// Register-file dump sequencer: reads x0..x(DumpCount-1) over the asynchronous read
// port and streams each register as an index byte followed by little-endian data bytes.
module regfile_dump_reader #(
   parameter int Width     = 32,
   parameter int RegNum    = 32,
   parameter int DumpCount = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [4:0]       rd_addr,
   input  logic [Width-1:0] rd_data,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);
   localparam int NBytes = Width / 8;
   localparam int BcW    = $clog2(NBytes + 1);
   localparam int IdxW   = $clog2(RegNum + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [BcW-1:0]   bcnt_q, bcnt_d;
   logic [Width-1:0] shift_q, shift_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             handshake;
   logic             last_reg;

   assign handshake = out_valid_q & out_ready;
   assign last_reg  = (idx_q == IdxW'(DumpCount - 1));

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
         rd_addr_q   <= 5'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         rd_addr_q   <= rd_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      rd_addr_d   = rd_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d     = '0;
               rd_addr_d = 5'd0;
               state_d   = ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         ADDR: begin
            // rd_data is only sampled here, so later writes cannot disturb this frame
            shift_d     = rd_data;
            out_data_d  = 8'(idx_q);
            out_valid_d = 1'b1;
            bcnt_d      = '0;
            state_d     = SEND;
         end
         SEND: begin
            if (handshake) begin
               if (bcnt_q < BcW'(NBytes)) begin
                  out_data_d = shift_q[7:0];
                  shift_d    = shift_q >> 4'd8;
                  bcnt_d     = bcnt_q + 1'b1;
               end else if (!last_reg) begin
                  idx_d       = idx_q + 1'b1;
                  rd_addr_d   = 5'(idx_q + 1'b1);
                  out_valid_d = 1'b0;
                  state_d     = ADDR;
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = DONE;
               end
            end else begin
               state_d = SEND;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign rd_addr   = rd_addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a 16-register dump instance and a
// single-register dump instance share one register-file model.
module tb_regfile_dump_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic        out_ready0 = 1'b1;
   logic        out_ready1 = 1'b1;
   logic [4:0]  rd_addr0, rd_addr1;
   logic [31:0] rd_data0, rd_data1;
   logic [7:0]  out_data0, out_data1;
   logic        out_valid0, out_valid1;
   logic        busy0, busy1, done0, done1;

   logic [31:0] rf [32];
   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          nbytes0 = 0, nbytes1 = 0;
   int          ndone0 = 0, ndone1 = 0;
   int          start_edge0 = 0, start_edge1 = 0;
   int          exp_lat0 = 97;
   int          base_b, base_d;

   assign rd_data0 = rf[rd_addr0];
   assign rd_data1 = rf[rd_addr1];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   regfile_dump_reader #(.Width(32), .RegNum(32), .DumpCount(16)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .busy(busy0), .done(done0)
   );

   regfile_dump_reader #(.Width(32), .RegNum(32), .DumpCount(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .busy(busy1), .done(done1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-computed stream for x0..x2, then index*0x01010101 (x3 overridable)
   task automatic push_dump(input logic [31:0] x3val);
      logic [7:0]  head [15];
      logic [31:0] v;
      head = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h78, 8'h56, 8'h34, 8'h12,
               8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
      for (int i = 0; i < 15; i++) q0.push_back(head[i]);
      for (int r = 3; r < 16; r++) begin
         v = (r == 3) ? x3val : (32'(r) * 32'h01010101);
         q0.push_back(8'(r));
         for (int b = 0; b < 4; b++) q0.push_back(v[8*b +: 8]);
      end
   endtask

   task automatic do_start0(input int lat);
      @(posedge clk); #1;
      start0      = 1'b1;
      exp_lat0    = lat;
      start_edge0 = cyc + 1;
      base_b      = nbytes0;
      base_d      = ndone0;
      @(posedge clk); #1;
      start0 = 1'b0;
      chk("busy_after_start", busy0, 1'b1);
   endtask

   task automatic wait_done0(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (ndone0 != base_d) break;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("done_pulses", ndone0 - base_d, 1);
      chk("byte_count", nbytes0 - base_b, 80);
      chk("sb_drained", q0.size(), 0);
      chk("busy_idle", busy0, 1'b0);
   endtask

   task automatic wait_bytes0(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (nbytes0 - base_b >= n) break;
      end
      chk("reach_byte", nbytes0 - base_b, n);
   endtask

   // Monitor: pops expected bytes on every accepted transfer, checks done timing
   task automatic monitor();
      int   pos = 0;
      logic pd0 = 1'b0;
      logic pd1 = 1'b0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pos = 0;
            pd0 = 1'b0;
            pd1 = 1'b0;
         end else begin
            if (out_valid0 && out_ready0) begin
               nbytes0++;
               if (q0.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb0_extra: got byte %0h expected none", out_data0);
               end else begin
                  e = q0.pop_front();
                  chk("sb0_byte", out_data0, e);
                  if (pos == 0) chk("rd_addr_hdr", rd_addr0, e[4:0]);
               end
               pos = (pos == 4) ? 0 : pos + 1;
            end
            if (out_valid1 && out_ready1) begin
               nbytes1++;
               if (q1.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb1_extra: got byte %0h expected none", out_data1);
               end else begin
                  chk("sb1_byte", out_data1, q1.pop_front());
               end
            end
            if (pd0) chk("busy0_after_done", busy0, 1'b0);
            if (pd1) chk("busy1_after_done", busy1, 1'b0);
            if (done0) begin
               ndone0++;
               chk("done0_latency", cyc + 1 - start_edge0, exp_lat0);
            end
            if (done1) begin
               ndone1++;
               chk("done1_latency", cyc + 1 - start_edge1, 7);
            end
            pd0 = done0;
            pd1 = done1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
      rf[1] = 32'h12345678;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_addr", rd_addr0, 5'd0);
      chk("rst_out_data", out_data0, 8'd0);
      chk("rst_out_valid", out_valid0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      rst = 1'b0;

      // Plain dump with out_ready held high
      push_dump(32'h03030303);
      do_start0(97);
      wait_done0(200);

      // Back-pressure for 10 cycles on byte 0x56 of x1
      push_dump(32'h03030303);
      do_start0(107);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (out_valid0 && out_data0 == 8'h56) break;
      end
      out_ready0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("stall_data", out_data0, 8'h56);
         chk("stall_valid", out_valid0, 1'b1);
      end
      out_ready0 = 1'b1;
      wait_done0(200);

      // start while busy is ignored
      push_dump(32'h03030303);
      do_start0(97);
      repeat (20) @(posedge clk);
      #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      wait_done0(200);
      repeat (10) @(posedge clk);
      #1;
      chk("no_requeue_busy", busy0, 1'b0);
      chk("no_requeue_done", ndone0 - base_d, 1);

      // Reset inside x5's frame, then start in the first cycle after reset
      push_dump(32'h03030303);
      do_start0(97);
      wait_bytes0(27, 100);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", out_valid0, 1'b0);
      chk("midrst_busy", busy0, 1'b0);
      chk("midrst_rd_addr", rd_addr0, 5'd0);
      chk("midrst_out_data", out_data0, 8'd0);
      chk("midrst_done", done0, 1'b0);
      q0.delete();
      push_dump(32'h03030303);
      rst         = 1'b0;
      start0      = 1'b1;
      start_edge0 = cyc + 1;
      base_b      = nbytes0;
      base_d      = ndone0;
      @(posedge clk); #1;
      start0 = 1'b0;
      chk("post_rst_busy", busy0, 1'b1);
      wait_done0(200);

      // Write x3 while x2's frame is in flight
      push_dump(32'hDEADBEEF);
      do_start0(97);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (out_valid0 && out_data0 == 8'h02 && nbytes0 - base_b == 10) break;
      end
      chk("x2_header_seen", out_data0, 8'h02);
      rf[3] = 32'hDEADBEEF;
      wait_done0(200);
      rf[3] = 32'h03030303;

      // Single-register dump
      for (int i = 0; i < 5; i++) q1.push_back(8'h00);
      @(posedge clk); #1;
      start1      = 1'b1;
      start_edge1 = cyc + 1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (ndone1 != 0) break;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("dc1_done_pulses", ndone1, 1);
      chk("dc1_bytes", nbytes1, 5);
      chk("dc1_sb_drained", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
